// File: rtl/stm_trace_delay_if.sv
// Trace-delay bus: sample input, delay configuration and the delayed sample output.
// The master drives samples and configuration; the slave is the delay line.
interface stm_trace_delay_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DELAY_W    = 8
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic [DELAY_W-1:0]    cfg_delay;
  logic                  cfg_we;
  logic                  flush;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic [DELAY_W-1:0]    delay_cur;
  logic                  primed;

  modport master (
    output din, din_valid, cfg_delay, cfg_we, flush,
    input  dout, dout_valid, delay_cur, primed
  );

  modport slave (
    input  din, din_valid, cfg_delay, cfg_we, flush,
    output dout, dout_valid, delay_cur, primed
  );
endinterface

// File: rtl/stm_trace_delay.sv
// Programmable trace delay line: circular buffer of MAX_DELAY+1 samples,
// registered read at (last write - D), with flush/reload clearing all history.
`ifndef DBG_TIMESTAMP_WIDTH
`define DBG_TIMESTAMP_WIDTH 16
`endif
`ifndef DBG_TRIGGER_DELAY
`define DBG_TRIGGER_DELAY 16
`endif

module stm_trace_delay #(
  parameter int DATA_WIDTH = `DBG_TIMESTAMP_WIDTH + 32 + 16,
  parameter int MAX_DELAY  = `DBG_TRIGGER_DELAY,
  parameter int DELAY_W    = 8
) (
  input  logic clk,
  input  logic rst,
  stm_trace_delay_if.slave trc
);

  localparam int DEPTH = MAX_DELAY + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = ((PTR_W > DELAY_W) ? PTR_W : DELAY_W) + 1;
  localparam int DMAX_BUS = (1 << DELAY_W) - 1;
  localparam int RST_DLY  = (MAX_DELAY < DMAX_BUS) ? MAX_DELAY : DMAX_BUS;

  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(MAX_DELAY);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_DEPTH = IDX_W'(DEPTH);
  localparam logic [DELAY_W:0]   FILL_ONE  = (DELAY_W+1)'(1);
  localparam logic [DELAY_W-1:0] DELAY_RST = DELAY_W'(RST_DLY);

  function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] req);
    if ({1'b0, req} > (DELAY_W+1)'(MAX_DELAY)) return DELAY_W'(MAX_DELAY);
    return req;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d, rd_idx;
  logic [DELAY_W-1:0]    delay_q, delay_d;
  logic [DELAY_W:0]      fill_q, fill_d, fill_full;
  logic                  primed_q, primed_d;
  logic                  dvld_q, dvld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  clear;
  logic [IDX_W-1:0]      last_x, rd_x;

  // wptr_q is the next slot to write; the newest stored sample sits one behind it.
  always_comb begin
    last_x = (wptr_q == '0) ? IDX_W'(MAX_DELAY) : (IDX_W'(wptr_q) - IDX_ONE);
    if (last_x >= IDX_W'(delay_q)) rd_x = last_x - IDX_W'(delay_q);
    else                           rd_x = last_x + IDX_DEPTH - IDX_W'(delay_q);
    rd_idx = rd_x[PTR_W-1:0];
  end

  always_comb begin
    clear   = trc.flush | trc.cfg_we;
    delay_d = trc.cfg_we ? clamp_delay(trc.cfg_delay) : delay_q;
    wptr_d  = (wptr_q == PTR_LAST) ? '0 : (wptr_q + PTR_ONE);

    // The sample presented alongside a flush survives it.
    vld_d         = clear ? '0 : vld_q;
    vld_d[wptr_q] = trc.din_valid;

    dvld_d = ~clear & vld_q[rd_idx];
    dout_d = dvld_d ? mem_q[rd_idx] : dout_q;

    fill_full = {1'b0, delay_q} + FILL_ONE;
    if (clear)                  fill_d = '0;
    else if (fill_q == fill_full) fill_d = fill_q;
    else                        fill_d = fill_q + FILL_ONE;
    primed_d = (fill_d == ({1'b0, delay_d} + FILL_ONE));
  end

  always_ff @(posedge clk) begin
    mem_q[wptr_q] <= trc.din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      wptr_q   <= '0;
      delay_q  <= DELAY_RST;
      fill_q   <= '0;
      primed_q <= 1'b0;
      dvld_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      vld_q    <= vld_d;
      wptr_q   <= wptr_d;
      delay_q  <= delay_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
      dvld_q   <= dvld_d;
      dout_q   <= dout_d;
    end
  end

  assign trc.dout       = dout_q;
  assign trc.dout_valid = dvld_q;
  assign trc.delay_cur  = delay_q;
  assign trc.primed     = primed_q;

endmodule
